mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the CPU data bus, downstream of the cpu core's load/store path. The core stores bytes to TXDATA; the block buffers them in a small FIFO and serialises them 8N1, LSB first, on o_tx. STATUS and BAUDDIV are readable in the same cycle so single-cycle loads work.

---
 rtl/riscv_periph_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/mmio_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_periph_pkg.sv
// Shared definitions for the memory-mapped peripherals on the core's data bus:
// UART register offsets, STATUS field positions and the transmitter state type.
package riscv_periph_pkg;

  localparam logic [3:0] UART_TXDATA  = 4'h0;
  localparam logic [3:0] UART_STATUS  = 4'h4;
  localparam logic [3:0] UART_BAUDDIV = 4'h8;

  localparam int STATUS_FULL    = 0;
  localparam int STATUS_EMPTY   = 1;
  localparam int STATUS_BUSY    = 2;
  localparam int STATUS_OVF     = 3;
  localparam int STATUS_CNT_LSB = 4;
  localparam int STATUS_CNT_MSB = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Registers are word-aligned, so the byte-lane bits of the offset are ignored.
  function automatic logic [3:0] word_offset(input logic [3:0] addr);
    return {addr[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push to a full FIFO is accepted only when a pop
// happens in the same cycle, otherwise it is dropped and flagged on drop.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             drop,
  output logic             empty_next
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full       = (count_r == CW'(DEPTH));
  assign empty      = (count_r == {CW{1'b0}});
  assign empty_next = (count_next_s == {CW{1'b0}});
  assign drop       = push & ~push_ok_s;
  assign head       = mem_r[rd_ptr_r];
  assign count      = count_r;

  // Accept/pop qualification and the next occupancy.
  always_comb begin
    pop_ok_s     = pop & ~empty;
    push_ok_s    = push & (~full | pop_ok_s);
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers and occupancy; a reset discards whatever is queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next_s;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, registers, TX FIFO,
// baud counter and the serialising state machine.
module mmio_uart_tx
  import riscv_periph_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 433
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state_r;
  uart_tx_state_t state_next_s;
  logic [15:0]    bauddiv_r;
  logic [15:0]    baud_cnt_r;
  logic [15:0]    baud_cnt_next_s;
  logic [2:0]     bit_idx_r;
  logic [2:0]     bit_idx_next_s;
  logic [7:0]     shift_r;
  logic [7:0]     shift_next_s;
  logic           tx_r;
  logic           tx_next_s;
  logic           irq_r;
  logic           overflow_r;
  logic [3:0]     offset_s;
  logic           push_s;
  logic           pop_s;
  logic           status_wr_s;
  logic           baud_wr_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic           fifo_empty_next_s;
  logic           fifo_drop_s;
  logic [7:0]     fifo_head_s;
  logic [CW-1:0]  fifo_count_s;
  logic [31:0]    status_s;
  logic           unused_s;

  assign offset_s    = word_offset(i_addr);
  assign push_s      = i_sel & i_we & (offset_s == UART_TXDATA);
  assign status_wr_s = i_sel & i_we & (offset_s == UART_STATUS);
  assign baud_wr_s   = i_sel & i_we & (offset_s == UART_BAUDDIV);
  assign unused_s    = ^i_wdata[31:16];
  assign o_tx        = tx_r;
  assign o_irq       = irq_r;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (i_clk),
    .rst        (i_reset),
    .push       (push_s),
    .push_data  (i_wdata[7:0]),
    .pop        (pop_s),
    .head       (fifo_head_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .count      (fifo_count_s),
    .drop       (fifo_drop_s),
    .empty_next (fifo_empty_next_s)
  );

  // STATUS word assembly.
  always_comb begin
    status_s                                = 32'h0000_0000;
    status_s[STATUS_FULL]                   = fifo_full_s;
    status_s[STATUS_EMPTY]                  = fifo_empty_s;
    status_s[STATUS_BUSY]                   = (state_r != IDLE);
    status_s[STATUS_OVF]                    = overflow_r;
    status_s[STATUS_CNT_MSB:STATUS_CNT_LSB] = 4'(fifo_count_s);
  end

  // Same-cycle load data; zero whenever no load targets us.
  always_comb begin
    o_rdata = 32'h0000_0000;
    if (i_sel & i_re) begin
      case (offset_s)
        UART_STATUS:  o_rdata = status_s;
        UART_BAUDDIV: o_rdata = {16'h0000, bauddiv_r};
        default:      o_rdata = 32'h0000_0000;
      endcase
    end else begin
      o_rdata = 32'h0000_0000;
    end
  end

  // Configuration register and the sticky overflow flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bauddiv_r  <= 16'(DEFAULT_DIV);
      overflow_r <= 1'b0;
    end else begin
      if (baud_wr_s) bauddiv_r <= i_wdata[15:0];
      if (fifo_drop_s) overflow_r <= 1'b1;
      else if (status_wr_s & i_wdata[STATUS_OVF]) overflow_r <= 1'b0;
    end
  end

  // Next-state logic; the counter reloads from BAUDDIV only at bit boundaries.
  always_comb begin
    state_next_s    = state_r;
    baud_cnt_next_s = baud_cnt_r;
    bit_idx_next_s  = bit_idx_r;
    shift_next_s    = shift_r;
    pop_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s           = 1'b1;
          shift_next_s    = fifo_head_s;
          baud_cnt_next_s = bauddiv_r;
          state_next_s    = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (baud_cnt_r == 16'd0) begin
          baud_cnt_next_s = bauddiv_r;
          bit_idx_next_s  = 3'd0;
          state_next_s    = DATA;
        end else begin
          baud_cnt_next_s = baud_cnt_r - 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt_r == 16'd0) begin
          baud_cnt_next_s = bauddiv_r;
          shift_next_s    = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_next_s = STOP;
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_cnt_next_s = baud_cnt_r - 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt_r == 16'd0) begin
          state_next_s = IDLE;
        end else begin
          baud_cnt_next_s = baud_cnt_r - 16'd1;
        end
      end
      default: state_next_s = IDLE;
    endcase

    case (state_next_s)
      IDLE:    tx_next_s = 1'b1;
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      STOP:    tx_next_s = 1'b1;
      default: tx_next_s = 1'b1;
    endcase
  end

  // State registers; line and interrupt are registered from next-state values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= 16'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
      irq_r      <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      baud_cnt_r <= baud_cnt_next_s;
      bit_idx_r  <= bit_idx_next_s;
      shift_r    <= shift_next_s;
      tx_r       <= tx_next_s;
      irq_r      <= fifo_empty_next_s & (state_next_s == IDLE);
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx: register map, frame timing,
// back-to-back frames, overflow, mid-frame divisor change and reset abort.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        we;
  logic        re;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  mmio_uart_tx #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (433)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_sel   (sel),
    .i_we    (we),
    .i_re    (re),
    .i_addr  (addr),
    .i_wdata (wdata),
    .o_rdata (rdata),
    .o_tx    (tx),
    .o_irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    sel = 1'b0; we = 1'b0; re = 1'b0; addr = 4'h0; wdata = 32'h0;
  endtask

  task automatic drive_write(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
  endtask

  task automatic drive_read(input logic [3:0] a);
    sel = 1'b1; we = 1'b0; re = 1'b1; addr = a; wdata = 32'h0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    drive_write(a, d);
    @(posedge clk);
    #1 bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    drive_read(a);
    #1 d = rdata;
    @(posedge clk);
    #1 bus_idle();
  endtask

  // Frame bit idx: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return d[idx-1];
    else return 1'b1;
  endfunction

  // Expected line k cycles after the push edge for a fixed bit period.
  function automatic logic exp_tx(input int k, input logic [7:0] d, input int period);
    if (k == 0) return 1'b1;
    else if (k <= 10 * period) return frame_bit(d, (k - 1) / period);
    else return 1'b1;
  endfunction

  logic [31:0] r;
  logic        e;
  logic        prev;
  int          falls;
  bit          done;
  bit          went_low;

  initial begin
    bus_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_held", tx, 1'b1);
    check("rst_irq_held", irq, 1'b1);
    rst = 1'b0;

    // Reset values and register map
    bus_read(4'h4, r);  check("status_rst", r, 32'h0000_0002);
    bus_read(4'h8, r);  check("baud_rst", r, 32'd433);
    @(negedge clk);
    check("idle_tx", tx, 1'b1);
    check("idle_irq", irq, 1'b1);
    bus_read(4'h0, r);  check("txdata_reads0", r, 32'h0);
    bus_read(4'hC, r);  check("reserved_reads0", r, 32'h0);
    bus_read(4'h6, r);  check("status_lane_ignored", r, 32'h0000_0002);
    @(negedge clk);
    sel = 1'b1; addr = 4'h4;
    #1 check("rdata_no_re", rdata, 32'h0);
    bus_idle();

    // BAUDDIV=3, one frame of 0xA5
    bus_write(4'h8, 32'hABCD_0003);
    bus_read(4'h8, r);  check("baud_upper0", r, 32'h0000_0003);
    bus_write(4'h0, 32'h0000_01A5);
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      check($sformatf("t2_tx[%0d]", k), tx, exp_tx(k, 8'hA5, 4));
      if (k == 20) check("t2_irq_busy", irq, 1'b0);
      if (k == 40) check("t2_irq_stop", irq, 1'b0);
      if (k == 41) check("t2_irq_done", irq, 1'b1);
    end

    // BAUDDIV=0, three back-to-back frames
    bus_write(4'h8, 32'h0);
    @(negedge clk);
    drive_write(4'h0, 32'h01);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      bus_idle();
      if (k >= 2 && k <= 11)       e = frame_bit(8'h01, k - 2);
      else if (k >= 13 && k <= 22) e = frame_bit(8'h02, k - 13);
      else if (k >= 24 && k <= 33) e = frame_bit(8'h03, k - 24);
      else                         e = 1'b1;
      check($sformatf("t3_tx[%0d]", k), tx, e);
      if (k == 1) drive_write(4'h0, 32'h02);
      else if (k == 2) drive_write(4'h0, 32'h03);
      else if (k == 3) begin
        drive_read(4'h4);
        #1 check("t3_status_cnt2", rdata, 32'h0000_0024);
      end else if (k == 14) begin
        drive_read(4'h4);
        #1 check("t3_status_cnt1", rdata, 32'h0000_0014);
      end else if (k == 35) begin
        drive_read(4'h4);
        #1 check("t3_status_drained", rdata, 32'h0000_0002);
        check("t3_irq", irq, 1'b1);
      end
    end
    @(negedge clk);
    bus_idle();

    // Overflow with FSM held busy
    bus_write(4'h8, 32'd200);
    for (int i = 0; i < 10; i++) bus_write(4'h0, 32'h0000_00FF);
    bus_read(4'h4, r);  check("t4_full_ovf", r, 32'h0000_008D);
    bus_write(4'h4, 32'h0000_0000);
    bus_read(4'h4, r);  check("t4_ovf_kept", r, 32'h0000_008D);
    bus_write(4'h4, 32'h0000_0008);
    bus_read(4'h4, r);  check("t4_ovf_clr", r, 32'h0000_0085);
    bus_write(4'h8, 32'h0);
    falls = 0;
    prev  = tx;
    done  = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (prev && !tx) falls++;
      prev = tx;
      if (irq) done = 1'b1;
    end
    check("t4_drain_irq", irq, 1'b1);
    check("t4_frames_after", falls, 32'd8);

    // BAUDDIV=7, change to 1 during data bit 2
    bus_write(4'h8, 32'd7);
    bus_write(4'h0, 32'h0000_006C);
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      bus_idle();
      if (k == 0)       e = 1'b1;
      else if (k <= 32) e = frame_bit(8'h6C, (k - 1) / 8);
      else if (k <= 44) e = frame_bit(8'h6C, 4 + (k - 33) / 2);
      else              e = 1'b1;
      check($sformatf("t5_tx[%0d]", k), tx, e);
      if (k == 26) drive_write(4'h8, 32'd1);
      if (k == 45) check("t5_irq", irq, 1'b1);
    end
    @(negedge clk);
    bus_idle();

    // Reset during data bit 4 with 3 bytes queued
    bus_write(4'h8, 32'd3);
    bus_write(4'h0, 32'h00);
    bus_write(4'h0, 32'h11);
    bus_write(4'h0, 32'h22);
    bus_write(4'h0, 32'h33);
    repeat (20) @(negedge clk);
    check("t6_bit4_low", tx, 1'b0);
    check("t6_irq_busy", irq, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_abort_tx", tx, 1'b1);
    check("t6_abort_irq", irq, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus_read(4'h4, r);  check("t6_status", r, 32'h0000_0002);
    bus_read(4'h8, r);  check("t6_baud_default", r, 32'd433);
    went_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (!tx) went_low = 1'b1;
    end
    check("t6_no_frames", went_low, 1'b0);
    check("t6_irq_idle", irq, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
